e_muldiv: RTL and testbench
===========================

# e_muldiv

Execute-stage multiply/divide unit with architectural HI/LO registers, sitting in E beside the ALU, directly upstream of the memory stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E-stage controller, models fixed multi-cycle latency with a busy counter, and drives HI/LO onto the E result path so MFHI/MFLO values flow into the E/M register and on to memory stage's `ALUout`. It also raises a stall request so the hazard unit holds D while an operation is in flight.

## Interface
- `MUL_CYCLES`, 5, busy cycles for MULT/MULTU
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU

- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  E-stage instruction is a mult/div-class op this cycle
- `op`  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (no-op)
- `a`  in  32  forwarded rs value
- `b`  in  32  forwarded rt value
- `d_is_md`  in  1  D-stage instruction is any of MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
- `busy`  out  1  operation in flight
- `md_stall`  out  1  `d_is_md & (busy | start_md)`, where `start_md = start & op∈{1..4}`; combinational
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- One clock; reset is asynchronous and active-high.
- State: `busy`, down-counter `cnt` (4 bits), pending `p_hi`/`p_lo`, `p_valid`, committed `hi`/`lo`.
- Idle (`busy=0`), at posedge with `start=1`:
  - MULT: {p_hi,p_lo} = $signed(a)*$signed(b) (64-bit). MULTU: unsigned product.
  - DIV: p_lo = a/b, p_hi = a%b, signed; quotient truncates toward zero, remainder takes dividend sign. DIVU: unsigned.
  - Operands captured at the start edge; later changes on `a`/`b` have no effect.
  - `cnt` ← MUL_CYCLES or DIV_CYCLES; `busy` ← 1; `p_valid` ← 1.
  - MTHI: `hi` ← a at that edge; MTLO: `lo` ← a; no busy.
  - op 0 or 7: nothing.
- Busy: each posedge `cnt` decrements; at the edge where `cnt` goes 1→0, `hi`/`lo` ← `p_hi`/`p_lo` (if `p_valid`), `busy` ← 0.
- Divide by zero (b=0 on DIV/DIVU): full DIV_CYCLES busy, `p_valid` ← 0, HI/LO unchanged at completion.
- `start` while `busy=1`: ignored entirely (incl. MTHI/MTLO); the hazard unit guarantees this never occurs, bench checks it is harmless.
- Completion edge with new `start`: the new op is accepted at the edge after `busy` falls, never the same edge (busy is sampled before decrement).

## Timing
- Reset values: `busy`=0, `cnt`=0, `hi`=0, `lo`=0, `p_hi`=`p_lo`=0, `p_valid`=0; `md_stall`=0 when inputs are 0.
- Start sampled at edge T: `busy` high during cycles T+1 … T+N (N = latency); new HI/LO visible after edge T+N; `busy` low in the same cycle.
- MTHI/MTLO: new value visible in the cycle after edge T.
- `md_stall` is purely combinational; asserts the same cycle `start` with op 1–4 is presented, so a following MFHI in D stalls immediately.
- Reset asserted mid-operation: all state cleared without waiting for clk; pending result discarded.
- `hi`/`lo` change only at commit, MTHI/MTLO, or reset.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> `busy`=0, `hi`=`lo`=0 before next edge; after MULT started, reset at cycle 3 -> HI/LO stay 0, busy 0.
- MULT a=0xFFFFFFFE (−2), b=3 -> `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
- DIV b=0 after MTHI 0x1234/MTLO 0x5678 -> busy 10 cycles, hi=0x1234, lo=0x5678 unchanged.
- Stall: start MULT with `d_is_md`=1 -> `md_stall`=1 in start cycle and all 5 busy cycles, 0 the cycle after; `d_is_md`=0 -> `md_stall`=0 throughout.
- Ignored start: during DIV busy, present MTLO a=0xDEAD and MULT -> no effect; final HI/LO equal the DIV result; change `a`/`b` after start -> result uses captured operands.

Source files
------------

// File: rtl/e_muldiv.sv
// e_muldiv: execute-stage multiply/divide unit with architectural HI/LO.
// Fixed-latency MULT/MULTU/DIV/DIVU run behind a busy down-counter and then
// commit to HI/LO. MTHI/MTLO write HI/LO directly. md_stall holds D while a
// mult/div-class instruction there would need the unit.
module e_muldiv #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_is_md,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {S_IDLE, S_BUSY} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] p_hi_q;
   logic [31:0] p_lo_q;
   logic        p_valid_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        b_zero;
   logic [31:0] div_b;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] quot_u;
   logic [31:0] rem_u;
   logic        start_md;

   // Arithmetic on the live operands; only sampled into p_hi/p_lo at the start edge.
   always_comb begin
      prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u = {32'd0, a} * {32'd0, b};
      b_zero = (b == 32'd0);
      // Divisor forced non-zero so a divide by zero never produces X; that result is discarded anyway.
      div_b  = b_zero ? 32'd1 : b;
      quot_s = $signed(a) / $signed(div_b);
      rem_s  = $signed(a) % $signed(div_b);
      quot_u = a / div_b;
      rem_u  = a % div_b;
   end

   // Stall D whenever a mult/div-class instruction there would see an in-flight or starting op.
   always_comb begin
      start_md = start && (op >= OP_MULT) && (op <= OP_DIVU);
      md_stall = d_is_md && (busy || start_md);
   end

   // Unit state: accept ops when idle, count down while busy, commit pending result on 1->0.
   // NOTE: every register, including the pending-result datapath, is cleared by reset so a
   // result in flight is discarded cleanly; all state updates use non-blocking assignments.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         p_hi_q    <= 32'd0;
         p_lo_q    <= 32'd0;
         p_valid_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        {p_hi_q, p_lo_q} <= (op == OP_MULT) ? prod_s : prod_u;
                        p_valid_q        <= 1'b1;
                        cnt_q            <= 4'(MUL_CYCLES);
                        state_q          <= S_BUSY;
                     end
                     OP_DIV, OP_DIVU: begin
                        p_lo_q    <= (op == OP_DIV) ? quot_s : quot_u;
                        p_hi_q    <= (op == OP_DIV) ? rem_s  : rem_u;
                        p_valid_q <= !b_zero;
                        cnt_q     <= 4'(DIV_CYCLES);
                        state_q   <= S_BUSY;
                     end
                     OP_MTHI: hi_q <= a;
                     OP_MTLO: lo_q <= a;
                     default: ;
                  endcase
               end
            end
            S_BUSY: begin
               // Any start while busy is ignored; the hazard unit never issues one.
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  if (p_valid_q) begin
                     hi_q <= p_hi_q;
                     lo_q <= p_lo_q;
                  end
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = (state_q == S_BUSY);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_e_muldiv.sv
// tb_e_muldiv: scoreboard bench for e_muldiv. Expected HI/LO are pushed when an
// op is started and popped when busy falls; stall and latency are checked per cycle.
module tb_e_muldiv;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_is_md;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   e_muldiv #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .d_is_md  (d_is_md),
      .busy     (busy),
      .md_stall (md_stall),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Count busy cycles (starting from n0 already seen), then pop and compare HI/LO.
   task automatic wait_done(input string tag, input int n0, input int lat, input logic dmd);
      int   n;
      exp_t e;
      n = n0;
      while (busy === 1'b1 && n < 40) begin
         check({tag, "_stall_busy"}, 32'(md_stall), 32'(dmd));
         n++;
         @(negedge clk);
      end
      check({tag, "_latency"}, 32'(n), 32'(lat));
      check({tag, "_stall_after"}, 32'(md_stall), 32'd0);
      check({tag, "_sb_size"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_hi"}, hi, e.hi);
         check({tag, "_lo"}, lo, e.lo);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic dmd, input int lat,
                         input logic [31:0] eh, input logic [31:0] el);
      @(negedge clk);
      start = 1'b1; op = o; a = va; b = vb; d_is_md = dmd;
      #1;
      check({tag, "_stall_start"}, 32'(md_stall), 32'(dmd));
      sb.push_back('{eh, el});
      @(negedge clk);
      // Scramble operands after the start edge: the result must use the captured values.
      start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
      wait_done(tag, 0, lat, dmd);
      d_is_md = 1'b0;
   endtask

   task automatic move_to(input logic [2:0] o, input logic [31:0] va);
      @(negedge clk);
      start = 1'b1; op = o; a = va;
      @(negedge clk);
      start = 1'b0; op = 3'd0; a = 32'd0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; d_is_md = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(md_stall), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 5,  32'h00000002, 32'hFFFFFFFA);
      run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu",  3'd4, 32'd7,        32'd2, 1'b0, 10, 32'd1,        32'd3);

      move_to(3'd5, 32'h1234);
      check("mthi_hi", hi, 32'h1234);
      check("mthi_lo", lo, 32'd3);
      move_to(3'd6, 32'h5678);
      check("mtlo_hi", hi, 32'h1234);
      check("mtlo_lo", lo, 32'h5678);

      run_op("div0", 3'd3, 32'd100, 32'd0, 1'b0, 10, 32'h1234, 32'h5678);

      // Starts presented while busy must be ignored.
      @(negedge clk);
      start = 1'b1; op = 3'd3; a = 32'hFFFFFFF9; b = 32'd2;
      sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD});
      @(negedge clk);
      check("ign_busy1", 32'(busy), 32'd1);
      op = 3'd6; a = 32'hDEAD;
      @(negedge clk);
      check("ign_busy2", 32'(busy), 32'd1);
      check("ign_mtlo_lo", lo, 32'h5678);
      op = 3'd1; a = 32'd5; b = 32'd5;
      @(negedge clk);
      start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      wait_done("ign", 2, 10, 1'b0);

      // Start held through completion: re-accepted only at the edge after busy falls.
      @(negedge clk);
      start = 1'b1; op = 3'd2; a = 32'd2; b = 32'd3;
      sb.push_back('{32'd0, 32'd6});
      @(negedge clk);
      wait_done("b2b", 0, 5, 1'b0);
      check("b2b_idle_gap", 32'(busy), 32'd0);
      @(negedge clk);
      check("b2b_restart", 32'(busy), 32'd1);
      start = 1'b0; op = 3'd0;
      sb.push_back('{32'd0, 32'd6});
      @(negedge clk);
      wait_done("b2b2", 1, 5, 1'b0);

      // Asynchronous reset in the middle of a multiply.
      move_to(3'd5, 32'hAAAA);
      check("pre_rst_hi", hi, 32'hAAAA);
      @(negedge clk);
      start = 1'b1; op = 3'd1; a = 32'hFFFFFFFE; b = 32'd3;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      @(negedge clk);
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_busy", 32'(busy), 32'd0);
      check("async_hi", hi, 32'd0);
      check("async_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_hi", hi, 32'd0);
      check("post_rst_lo", lo, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
